seg_disp_arbiter: RTL and testbench

Owns the board's 8-digit multiplexed 7-segment display and shares it between two 32-bit requesters, e.g. the CPU result bus and the debug register view. It handles digit-scan timing, anti-ghosting blanking, round-robin arbitration with a minimum hold time, tear-free frame snapshots, hex-to-segment encoding and optional leading-zero blanking. It connects directly to the top-level LEDSEL/LEDOUT pins.

---
 rtl/seg_disp_arbiter.sv | 108 ++++++++++
 tb/tb_seg_disp_arbiter.sv | 100 ++++++++++
 2 files changed

// File: rtl/seg_disp_arbiter.sv
// seg_disp_arbiter: shares the 8-digit multiplexed 7-segment display between two 32-bit requesters
module seg_disp_arbiter #(
    parameter int SCAN_DIV    = 20000,
    parameter int BLANK_CYC   = 500,
    parameter int HOLD_FRAMES = 4
) (
    input  logic        clk100MHz,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [1:0]  lzb,
    output logic [1:0]  grant,
    output logic        frame_done,
    output logic [7:0]  LEDSEL,
    output logic [7:0]  LEDOUT
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(HOLD_FRAMES + 1);
    localparam logic [7:0] SEG [16] = '{8'h88, 8'hED, 8'hA2, 8'hA4, 8'hC5, 8'h94, 8'h90, 8'hAD,
                                        8'h80, 8'h84, 8'hA0, 8'hD0, 8'hF2, 8'hE0, 8'h92, 8'h93};
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic          r_rr_last;
    logic [FW-1:0] r_frames;
    logic [31:0]   r_snap;
    logic          r_snap_lzb;
    logic          r_frame_done;
    logic [7:0]    r_ledsel, r_ledout;
    logic          w_slot_tick, w_frame_end, w_new_grant, w_hold_done, w_blank, w_lz;
    logic [4:0]    w_shift;
    logic [3:0]    w_nib;

    assign w_slot_tick = r_cnt == CW'(SCAN_DIV - 1);
    assign w_frame_end = w_slot_tick && r_idx == 3'd7;
    assign w_hold_done = r_frames >= FW'(HOLD_FRAMES);
    assign w_shift     = {r_idx, 2'b00};
    assign w_nib       = r_snap[w_shift +: 4];
    assign w_lz        = r_snap_lzb && r_idx != 3'd0 && (r_snap >> w_shift) == 32'd0;
    assign w_blank     = r_cnt < CW'(BLANK_CYC) || r_state == IDLE;
    assign grant       = {r_state == OWN1, r_state == OWN0};
    assign frame_done  = r_frame_done;
    assign LEDSEL      = r_ledsel;
    assign LEDOUT      = r_ledout;

    // Slot prescaler and digit index; a frame is eight slots
    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            r_cnt <= w_slot_tick ? '0 : r_cnt + 1'b1;
            r_idx <= r_idx + 3'(w_slot_tick);
        end
    end

    // Arbitration decision: round-robin on ties, owner keeps the display until its hold time expires
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (req == 2'b11) ? (r_rr_last ? OWN0 : OWN1) : req[0] ? OWN0 : req[1] ? OWN1 : IDLE;
            OWN0:    w_next = !req[0] ? (req[1] ? OWN1 : IDLE) : (req[1] && w_hold_done) ? OWN1 : OWN0;
            OWN1:    w_next = !req[1] ? (req[0] ? OWN0 : IDLE) : (req[0] && w_hold_done) ? OWN0 : OWN1;
            default: w_next = IDLE;
        endcase
        w_new_grant = w_next != IDLE && w_next != r_state;
    end

    // Arbiter state register, advanced only at frame end
    always_ff @(posedge clk100MHz) begin
        if (rst) r_state <= IDLE;
        else if (w_frame_end) r_state <= w_next;
    end

    // Ownership bookkeeping and tear-free snapshot of the owner's value, taken on the same edge as the grant
    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            r_rr_last  <= 1'b1;
            r_frames   <= '0;
            r_snap     <= '0;
            r_snap_lzb <= 1'b0;
        end else if (w_frame_end) begin
            r_snap     <= (w_next == OWN1) ? data1 : data0;
            r_snap_lzb <= (w_next == OWN1) ? lzb[1] : lzb[0];
            if (w_new_grant) begin
                r_frames  <= FW'(1);
                r_rr_last <= w_next == OWN1;
            end else if (w_next != IDLE && !w_hold_done) begin
                r_frames <= r_frames + 1'b1;
            end
        end
    end

    // Registered pin drive: ghost-guard blanking, digit select and segment encoding with leading-zero blanking
    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            r_ledsel     <= 8'hFF;
            r_ledout     <= 8'hFF;
            r_frame_done <= 1'b0;
        end else begin
            r_ledsel     <= w_blank ? 8'hFF : ~(8'd1 << r_idx);
            r_ledout     <= (w_blank || w_lz) ? 8'hFF : SEG[w_nib];
            r_frame_done <= w_frame_end;
        end
    end
endmodule

// File: tb/tb_seg_disp_arbiter.sv
// tb_seg_disp_arbiter: directed checks of scan timing, arbitration, snapshot and blanking
module tb_seg_disp_arbiter;
    logic        clk100MHz = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  lzb = 2'b00;
    logic [31:0] data0 = '0;
    logic [31:0] data1 = '0;
    logic [1:0]  grant;
    logic        frame_done;
    logic [7:0]  LEDSEL, LEDOUT;
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    seg_disp_arbiter #(.SCAN_DIV(10), .BLANK_CYC(2), .HOLD_FRAMES(2)) dut (
        .clk100MHz(clk100MHz), .rst(rst), .req(req), .data0(data0), .data1(data1), .lzb(lzb),
        .grant(grant), .frame_done(frame_done), .LEDSEL(LEDSEL), .LEDOUT(LEDOUT)
    );

    always #5 clk100MHz = ~clk100MHz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic go(input int n);
        while (cyc < n) begin
            @(negedge clk100MHz);
            cyc++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk100MHz);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_fd", 32'(frame_done), 32'h0);
        chk("rst_ledsel", 32'(LEDSEL), 32'hFF);
        chk("rst_ledout", 32'(LEDOUT), 32'hFF);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        do_reset();
        go(40);  chk("idle_sel", 32'(LEDSEL), 32'hFF); chk("idle_out", 32'(LEDOUT), 32'hFF);
        go(79);  chk("fd_before", 32'(frame_done), 32'h0);
        go(80);  chk("fd_pulse1", 32'(frame_done), 32'h1); chk("idle_grant", 32'(grant), 32'h0);
                 chk("idle_sel2", 32'(LEDSEL), 32'hFF);
        go(81);  chk("fd_single", 32'(frame_done), 32'h0);
        go(160); chk("fd_pulse2", 32'(frame_done), 32'h1); chk("idle_grant2", 32'(grant), 32'h0);
        req = 2'b01; data0 = 32'h1234ABCD;
        go(240); chk("grant0", 32'(grant), 32'h1);
        go(242); chk("guard_sel", 32'(LEDSEL), 32'hFF); chk("guard_out", 32'(LEDOUT), 32'hFF);
        go(243); chk("idx0_sel", 32'(LEDSEL), 32'hFE); chk("idx0_out", 32'(LEDOUT), 32'hE0);
        go(250); chk("idx0_end_sel", 32'(LEDSEL), 32'hFE); chk("idx0_end_out", 32'(LEDOUT), 32'hE0);
        go(251); chk("idx1_guard", 32'(LEDSEL), 32'hFF);
        go(253); chk("idx1_sel", 32'(LEDSEL), 32'hFD); chk("idx1_out", 32'(LEDOUT), 32'hF2);
        go(313); chk("idx7_sel", 32'(LEDSEL), 32'h7F); chk("idx7_out", 32'(LEDOUT), 32'hED);
        go(315); lzb = 2'b01; data0 = 32'h000000A0;
        go(323); chk("lzb_idx0_sel", 32'(LEDSEL), 32'hFE); chk("lzb_idx0", 32'(LEDOUT), 32'h88);
        go(333); chk("lzb_idx1", 32'(LEDOUT), 32'hA0);
        go(343); chk("lzb_idx2", 32'(LEDOUT), 32'hFF);
        go(393); chk("lzb_idx7", 32'(LEDOUT), 32'hFF);
        go(395); data0 = 32'h0;
        go(403); chk("lzb_zero_idx0", 32'(LEDOUT), 32'h88);
        go(413); chk("lzb_zero_idx1", 32'(LEDOUT), 32'hFF);
        go(415); lzb = 2'b00; data0 = 32'h11111111;
        go(483); chk("snap_old_a", 32'(LEDOUT), 32'hED);
        go(510); data0 = 32'h22222222;
        go(513); chk("snap_old_b", 32'(LEDOUT), 32'hED);
        go(553); chk("snap_old_c", 32'(LEDOUT), 32'hED);
        go(563); chk("snap_new_a", 32'(LEDOUT), 32'hA2);
        go(633); chk("snap_new_b", 32'(LEDOUT), 32'hA2);
        do_reset();
        req = 2'b11; data0 = 32'h11111111; data1 = 32'h22222222;
        go(80);  chk("rr_f1", 32'(grant), 32'h1);
        go(160); chk("rr_f2", 32'(grant), 32'h1);
        go(240); chk("rr_f3", 32'(grant), 32'h2);
        go(243); chk("rr_data1", 32'(LEDOUT), 32'hA2);
        go(320); chk("rr_f4", 32'(grant), 32'h2);
        go(400); chk("rr_f5", 32'(grant), 32'h1);
        go(401); req = 2'b10;
        go(480); chk("handover", 32'(grant), 32'h2);
        go(520); do_reset();
        go(79);  chk("restart_fd0", 32'(frame_done), 32'h0);
        go(80);  chk("restart_fd1", 32'(frame_done), 32'h1); chk("restart_grant", 32'(grant), 32'h2);
        go(83);  chk("restart_sel", 32'(LEDSEL), 32'hFE); chk("restart_out", 32'(LEDOUT), 32'hA2);
        req = 2'b00;
        go(160); chk("drop_idle", 32'(grant), 32'h0);
        go(163); chk("drop_blank", 32'(LEDSEL), 32'hFF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
